// File: rtl/cpu_rf_pkg.sv
// Shared register-file types and default geometry, also used by the decode stage.
package cpu_rf_pkg;

  typedef enum logic {RF_IDLE, RF_SWEEP} rf_state_t;

  localparam int unsigned RF_WIDTH = 8;
  localparam int unsigned RF_DEPTH = 8;

endpackage

// File: rtl/rf_entry.sv
// Single register-file entry: async reset, write enable, synchronous clear.
module rf_entry #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       o_q <= '0;
    else if (i_clr) o_q <= '0;
    else if (i_we)  o_q <= i_d;
  end

endmodule

// File: rtl/reg_file.sv
// General-purpose register bank: 1 write / 2 read ports, optional zero entry,
// optional write-to-read bypass and a one-entry-per-cycle hardware clear sweep.
module reg_file
  import cpu_rf_pkg::*;
#(
  parameter int unsigned WIDTH   = RF_WIDTH,
  parameter int unsigned DEPTH   = RF_DEPTH,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b0,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             wr_drop
);

  rf_state_t        r_state;
  rf_state_t        w_state_nxt;
  logic [AW-1:0]    r_ptr;
  logic             r_wr_drop;
  logic             w_sweep;
  logic             w_wr_acc;
  logic [WIDTH-1:0] w_q [DEPTH];

  assign w_sweep  = (r_state == RF_SWEEP);
  assign w_wr_acc = we && (r_state == RF_IDLE);
  assign clr_busy = w_sweep;
  assign wr_drop  = r_wr_drop;

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_entry
    if (ZERO_R0 && g == 0) begin : g_zero
      assign w_q[g] = '0;
    end else begin : g_reg
      rf_entry #(.WIDTH(WIDTH)) u_entry (
        .clk   (clk),
        .rst   (rst),
        .i_we  (w_wr_acc && (waddr == AW'(g))),
        .i_clr (w_sweep && (r_ptr == AW'(g))),
        .i_d   (wdata),
        .o_q   (w_q[g])
      );
    end
  end

  // Bypass only forwards accepted writes; a hardwired zero entry never forwards.
  always_comb begin
    rdata_a = w_q[raddr_a];
    rdata_b = w_q[raddr_b];
    if (BYPASS && w_wr_acc && !(ZERO_R0 && waddr == '0)) begin
      if (waddr == raddr_a) rdata_a = wdata;
      if (waddr == raddr_b) rdata_b = wdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RF_IDLE:  if (clr_req) w_state_nxt = RF_SWEEP;
      RF_SWEEP: if (r_ptr == AW'(DEPTH - 1)) w_state_nxt = RF_IDLE;
      default:  w_state_nxt = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RF_IDLE;
      r_ptr     <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_sweep ? r_ptr + AW'(1) : '0;
      r_wr_drop <= we && w_sweep;
    end
  end

endmodule
